// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with nibble-swap engine.
// The module parameters take their defaults from here.
package regfile_pkg;

    localparam int NIB_W_DEF     = 4;
    localparam int DATA_W_DEF    = 28;
    localparam int BOARD_IDX_DEF = 0;
    localparam int GOAL_IDX_DEF  = 1;
    localparam int CNT_IDX_DEF   = 7;

    localparam logic [DATA_W_DEF-1:0] INIT_BOARD_DEF = 28'hADEB567;
    localparam logic [DATA_W_DEF-1:0] INIT_GOAL_DEF  = 28'h5679DAF;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        COMMIT
    } swap_state_t;

endpackage

// File: rtl/nib_swap_fsm.sv
// Swap sequencer: captures a request, checks the nibble indices, strobes commit,
// and then pulses done. Requests that arrive while the engine is busy are ignored.
module nib_swap_fsm
    import regfile_pkg::*;
#(
    parameter int NIBS = 7,
    parameter int SW_W = $clog2(NIBS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            swap_req,
    input  logic [SW_W-1:0] swap_a,
    input  logic [SW_W-1:0] swap_b,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            commit,
    output logic [SW_W-1:0] lat_a,
    output logic [SW_W-1:0] lat_b
);

    swap_state_t     state_q;
    logic [SW_W-1:0] a_q, b_q;
    logic            busy_q, done_q, err_q;
    logic            bad_idx;

    assign bad_idx = (int'(a_q) >= NIBS) || (int'(b_q) >= NIBS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (swap_req) begin
                        a_q     <= swap_a;
                        b_q     <= swap_b;
                        busy_q  <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (bad_idx) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign commit = (state_q == COMMIT);
    assign lat_a  = a_q;
    assign lat_b  = b_q;

endmodule

// File: rtl/regfile_nib_swap.sv
// Register file with nibble-masked write port, same-cycle write forwarding,
// per-register write protection, a board nibble-swap engine and a board==goal flag.
module regfile_nib_swap
    import regfile_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                NIB_W      = NIB_W_DEF,
    parameter int                DEPTH      = 16,
    parameter int                NRD        = 2,
    parameter int                BOARD_IDX  = BOARD_IDX_DEF,
    parameter int                GOAL_IDX   = GOAL_IDX_DEF,
    parameter int                CNT_IDX    = CNT_IDX_DEF,
    parameter logic [DEPTH-1:0]  RO_MASK    = 16'h0002,
    parameter logic [DATA_W-1:0] INIT_BOARD = INIT_BOARD_DEF,
    parameter logic [DATA_W-1:0] INIT_GOAL  = INIT_GOAL_DEF,
    localparam int               NIBS       = DATA_W / NIB_W,
    localparam int               ADDR_W     = $clog2(DEPTH),
    localparam int               SW_W       = $clog2(NIBS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*ADDR_W-1:0]   src,
    output logic [NRD*DATA_W-1:0]   rdata,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       dst,
    input  logic [NIBS-1:0]         wmask,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    swap_req,
    input  logic [SW_W-1:0]         swap_a,
    input  logic [SW_W-1:0]         swap_b,
    output logic                    swap_busy,
    output logic                    swap_done,
    output logic [DATA_W-1:0]       board,
    output logic [DATA_W-1:0]       cnt,
    output logic                    comp,
    output logic                    err
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]            wr_bits, wr_merged, swapped;
    logic                         wr_ro, collide, wr_ok;
    logic                         commit, fsm_err;
    logic [SW_W-1:0]              lat_a, lat_b;
    logic                         err_q, err_d, comp_q, comp_d;

    nib_swap_fsm #(.NIBS(NIBS), .SW_W(SW_W)) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .swap_req (swap_req),
        .swap_a   (swap_a),
        .swap_b   (swap_b),
        .busy     (swap_busy),
        .done     (swap_done),
        .err      (fsm_err),
        .commit   (commit),
        .lat_a    (lat_a),
        .lat_b    (lat_b)
    );

    always_comb begin
        wr_bits = '0;
        for (int n = 0; n < NIBS; n++) wr_bits[n*NIB_W +: NIB_W] = {NIB_W{wmask[n]}};
    end

    assign wr_ro     = RO_MASK[dst];
    assign wr_merged = (regs_q[dst] & ~wr_bits) | (wdata & wr_bits);
    // The swap engine owns BOARD and CNT during its commit cycle.
    assign collide   = commit && (dst == ADDR_W'(BOARD_IDX) || dst == ADDR_W'(CNT_IDX));
    assign wr_ok     = we && !wr_ro && !collide;

    always_comb begin
        swapped = regs_q[BOARD_IDX];
        for (int n = 0; n < NIBS; n++) begin
            if (SW_W'(n) == lat_a)
                swapped[n*NIB_W +: NIB_W] = regs_q[BOARD_IDX][int'(lat_b)*NIB_W +: NIB_W];
            else if (SW_W'(n) == lat_b)
                swapped[n*NIB_W +: NIB_W] = regs_q[BOARD_IDX][int'(lat_a)*NIB_W +: NIB_W];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[dst] = wr_merged;
        if (commit) begin
            regs_d[BOARD_IDX] = swapped;
            regs_d[CNT_IDX]   = regs_q[CNT_IDX] + DATA_W'(1);
        end
        err_d  = we && (wr_ro || collide);
        comp_d = (regs_q[BOARD_IDX] == regs_q[GOAL_IDX]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q            <= '0;
            regs_q[BOARD_IDX] <= INIT_BOARD;
            regs_q[GOAL_IDX]  <= INIT_GOAL;
            err_q             <= 1'b0;
            comp_q            <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
            comp_q <= comp_d;
        end
    end

    // Forwarding shows the port write only; a swap commit appears the next cycle.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = src[k*ADDR_W +: ADDR_W];
        assign rdata[k*DATA_W +: DATA_W] = (we && !wr_ro && dst == ra) ? wr_merged : regs_q[ra];
    end

    assign board = regs_q[BOARD_IDX];
    assign cnt   = regs_q[CNT_IDX];
    assign comp  = comp_q;
    assign err   = err_q | fsm_err;

endmodule

// File: tb/tb_regfile_nib_swap.sv
// Directed bench for regfile_nib_swap: drives on negedge, samples #1 later.
module tb_regfile_nib_swap;

    localparam int DATA_W = 28;
    localparam int ADDR_W = 4;
    localparam int NIBS   = 7;
    localparam int SW_W   = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [2*ADDR_W-1:0]   src;
    logic [2*DATA_W-1:0]   rdata;
    logic                  we;
    logic [ADDR_W-1:0]     dst;
    logic [NIBS-1:0]       wmask;
    logic [DATA_W-1:0]     wdata;
    logic                  swap_req;
    logic [SW_W-1:0]       swap_a, swap_b;
    logic                  swap_busy, swap_done, comp, err;
    logic [DATA_W-1:0]     board, cnt;

    int n_chk = 0;
    int n_err = 0;

    regfile_nib_swap dut (
        .clk(clk), .rst_n(rst_n), .src(src), .rdata(rdata),
        .we(we), .dst(dst), .wmask(wmask), .wdata(wdata),
        .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
        .swap_busy(swap_busy), .swap_done(swap_done),
        .board(board), .cnt(cnt), .comp(comp), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rd0();
        return rdata[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rd1();
        return rdata[2*DATA_W-1:DATA_W];
    endfunction

    initial begin
        rst_n = 1'b0; src = '0; we = 1'b0; dst = '0; wmask = '0; wdata = '0;
        swap_req = 1'b0; swap_a = '0; swap_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        src = {4'd1, 4'd0};
        #1;
        chk("rst_board", board, 28'hADEB567);
        chk("rst_goal",  rd1(), 28'h5679DAF);
        chk("rst_cnt",   cnt, 0);
        chk("rst_comp",  comp, 0);
        chk("rst_busy",  swap_busy, 0);
        chk("rst_err",   err, 0);

        // masked write with same-cycle forwarding
        we = 1'b1; dst = 4'd3; wmask = 7'b0000011; wdata = 28'hFFFFFFF; src = {4'd1, 4'd3};
        #1 chk("fwd_rd0", rd0(), 28'h00000FF);
        step();
        we = 1'b0;
        #1 chk("reg3_after", rd0(), 28'h00000FF);
        chk("wr_no_err", err, 0);

        // empty mask: no change, no error
        we = 1'b1; dst = 4'd3; wmask = '0; wdata = 28'h1234567;
        step();
        we = 1'b0;
        #1 chk("mask0_reg3", rd0(), 28'h00000FF);
        chk("mask0_err", err, 0);

        // write to read-only goal register
        we = 1'b1; dst = 4'd1; wmask = 7'h7F; wdata = 28'h0;
        step();
        we = 1'b0;
        #1 chk("ro_goal", rd1(), 28'h5679DAF);
        chk("ro_err", err, 1);
        step();
        chk("ro_err_clr", err, 0);

        // swap nibbles 0 and 1
        swap_req = 1'b1; swap_a = 3'd0; swap_b = 3'd1;
        step();
        swap_req = 1'b0;
        chk("sw_latch_busy", swap_busy, 1);
        chk("sw_latch_done", swap_done, 0);
        step();
        chk("sw_commit_busy", swap_busy, 1);
        chk("sw_commit_board", board, 28'hADEB567);
        step();
        chk("sw_idle_busy", swap_busy, 0);
        chk("sw_done", swap_done, 1);
        chk("sw_board", board, 28'hADEB576);
        chk("sw_cnt", cnt, 1);
        step();
        chk("sw_done_clr", swap_done, 0);

        // illegal index, plus a request while busy that must be ignored
        swap_req = 1'b1; swap_a = 3'd7; swap_b = 3'd0;
        step();
        swap_a = 3'd2; swap_b = 3'd3;
        chk("bad_busy", swap_busy, 1);
        step();
        swap_req = 1'b0;
        chk("bad_err", err, 1);
        chk("bad_done", swap_done, 0);
        chk("bad_busy_clr", swap_busy, 0);
        step();
        chk("bad_done2", swap_done, 0);
        chk("bad_err_clr", err, 0);
        chk("bad_cnt", cnt, 1);
        chk("bad_board", board, 28'hADEB576);

        // valid swap with a competing request held during LATCH and COMMIT
        swap_req = 1'b1; swap_a = 3'd0; swap_b = 3'd1;
        step();
        swap_a = 3'd2; swap_b = 3'd3;
        step();
        step();
        swap_req = 1'b0;
        chk("hold_done", swap_done, 1);
        chk("hold_board", board, 28'hADEB567);
        chk("hold_cnt", cnt, 2);
        step();
        step();
        chk("hold_busy", swap_busy, 0);
        chk("hold_cnt2", cnt, 2);

        // board := goal -> comp rises one cycle later
        we = 1'b1; dst = 4'd0; wmask = 7'h7F; wdata = 28'h5679DAF;
        step();
        we = 1'b0;
        chk("comp_board", board, 28'h5679DAF);
        chk("comp_lag", comp, 0);
        step();
        chk("comp_set", comp, 1);

        // a==b swap with a port write to cnt in the COMMIT cycle
        swap_req = 1'b1; swap_a = 3'd2; swap_b = 3'd2;
        step();
        swap_req = 1'b0;
        step();
        we = 1'b1; dst = 4'd7; wmask = 7'h7F; wdata = 28'h0000123;
        step();
        we = 1'b0;
        chk("col_cnt", cnt, 3);
        chk("col_err", err, 1);
        chk("col_done", swap_done, 1);
        chk("col_board", board, 28'h5679DAF);

        // write to an unrelated register in the COMMIT cycle proceeds
        swap_req = 1'b1; swap_a = 3'd4; swap_b = 3'd4;
        step();
        swap_req = 1'b0;
        step();
        we = 1'b1; dst = 4'd5; wmask = 7'h7F; wdata = 28'h0ABCDEF;
        step();
        we = 1'b0; src = {4'd1, 4'd5};
        #1 chk("oth_reg5", rd0(), 28'h0ABCDEF);
        chk("oth_err", err, 0);
        chk("oth_cnt", cnt, 4);

        // reset during COMMIT: no commit, no done
        swap_req = 1'b1; swap_a = 3'd0; swap_b = 3'd6;
        step();
        swap_req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_busy", swap_busy, 0);
        chk("mid_done", swap_done, 0);
        chk("mid_board", board, 28'hADEB567);
        chk("mid_cnt", cnt, 0);
        step();
        chk("mid_done2", swap_done, 0);
        chk("mid_board2", board, 28'hADEB567);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
